// File: rtl/nrzi_decoder_unstuffer.sv
// Full-speed receive path: NRZI decode of J/K/SE0 samples, bit-unstuffing and EOP detection.
// All outputs are registered, so each strobe appears one clk12_i cycle after its en_i sample.
module nrzi_decoder_unstuffer #(
  parameter logic        INITIAL_VALUE      = 1'b1,
  parameter logic        ZERO_AS_TRANSITION = 1'b1,
  parameter int unsigned MAX_ONES           = 6
) (
  input  logic       clk12_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       line_i,
  input  logic       se0_i,
  output logic       data_o,
  output logic       valid_o,
  output logic       eop_o,
  output logic       err_o,
  output logic [1:0] dbg_state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_SE0  = 2'd2;

  localparam logic [2:0] MAX_ONES_C = 3'(MAX_ONES);

  logic [1:0] r_state;
  logic       r_prev;
  logic [2:0] r_ones;
  logic [1:0] r_se0cnt;
  logic       r_data;
  logic       r_valid;
  logic       r_eop;
  logic       r_err;

  logic       w_dec;
  logic [1:0] w_state_n;
  logic       w_prev_n;
  logic [2:0] w_ones_n;
  logic [1:0] w_se0cnt_n;
  logic       w_data_n;
  logic       w_valid_n;
  logic       w_eop_n;
  logic       w_err_n;

  assign w_dec = ZERO_AS_TRANSITION ? (line_i ~^ r_prev) : (line_i ^ r_prev);

  // Strobe semantics: valid_o/eop_o/err_o are single-cycle pulses with no back-pressure;
  // the consumer must take data_o on the cycle valid_o is high. valid_o and eop_o are exclusive.
  always_comb begin
    w_state_n  = r_state;
    w_prev_n   = r_prev;
    w_ones_n   = r_ones;
    w_se0cnt_n = r_se0cnt;
    w_data_n   = r_data;
    w_valid_n  = 1'b0;
    w_eop_n    = 1'b0;
    w_err_n    = 1'b0;
    if (en_i) begin
      case (r_state)
        S_IDLE: begin
          // Only a K wakes the receiver; J and SE0 leave prev at the idle level.
          if (!se0_i && !line_i) begin
            w_state_n = S_RECV;
            w_data_n  = w_dec;
            w_valid_n = 1'b1;
            w_ones_n  = 3'd0;
            w_prev_n  = line_i;
          end
        end
        S_RECV: begin
          if (se0_i) begin
            w_state_n  = S_SE0;
            w_se0cnt_n = 2'd1;
            w_ones_n   = 3'd0;
          end else begin
            w_prev_n = line_i;
            if (r_ones == MAX_ONES_C) begin
              w_ones_n = 3'd0;
              w_err_n  = w_dec;
            end else begin
              w_data_n  = w_dec;
              w_valid_n = 1'b1;
              w_ones_n  = w_dec ? (r_ones + 3'd1) : 3'd0;
            end
          end
        end
        S_SE0: begin
          if (se0_i) begin
            // Four SE0 samples in a row is a bus reset, not an EOP.
            if (r_se0cnt == 2'd3) begin
              w_state_n  = S_IDLE;
              w_prev_n   = INITIAL_VALUE;
              w_ones_n   = 3'd0;
              w_se0cnt_n = 2'd0;
            end else begin
              w_se0cnt_n = r_se0cnt + 2'd1;
            end
          end else begin
            w_eop_n    = 1'b1;
            w_err_n    = !line_i;
            w_state_n  = S_IDLE;
            w_prev_n   = INITIAL_VALUE;
            w_ones_n   = 3'd0;
            w_se0cnt_n = 2'd0;
          end
        end
        default: begin
          w_state_n  = S_IDLE;
          w_prev_n   = INITIAL_VALUE;
          w_ones_n   = 3'd0;
          w_se0cnt_n = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk12_i) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_prev   <= INITIAL_VALUE;
      r_ones   <= 3'd0;
      r_se0cnt <= 2'd0;
      r_data   <= 1'b0;
      r_valid  <= 1'b0;
      r_eop    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_prev   <= w_prev_n;
      r_ones   <= w_ones_n;
      r_se0cnt <= w_se0cnt_n;
      r_data   <= w_data_n;
      r_valid  <= w_valid_n;
      r_eop    <= w_eop_n;
      r_err    <= w_err_n;
    end
  end

  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign eop_o       = r_eop;
  assign err_o       = r_err;
  assign dbg_state_o = r_state;

endmodule
